// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with load-use stall control and EX operand forwarding.
// Optional PERF_COUNT_EN adds bubble_count / flush_count event counters.
module id_ex_operand_stage #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned CTRL_W = 8
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [4:0]        id_rs1_addr,
    input  logic [4:0]        id_rs2_addr,
    input  logic [4:0]        id_rd_addr,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_alu_src_imm,
    input  logic              flush,
    input  logic              fwd_rs1_mem,
    input  logic              fwd_rs2_mem,
    input  logic              fwd_rs1_wb,
    input  logic              fwd_rs2_wb,
    input  logic [XLEN-1:0]   mem_result,
    input  logic [XLEN-1:0]   wb_result,
    output logic              stall_if_id,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_imm,
    output logic [4:0]        ex_rd_addr,
    output logic [4:0]        ex_rs1_addr,
    output logic [4:0]        ex_rs2_addr,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic [XLEN-1:0]   ex_operand_a,
    output logic [XLEN-1:0]   ex_operand_b,
    output logic [XLEN-1:0]   ex_store_data
`ifdef PERF_COUNT_EN
    ,
    output logic [31:0]       bubble_count,
    output logic [31:0]       flush_count
`endif
);

    typedef enum logic [0:0] {StRun, StBubble} state_e;

    state_e state_q, state_d;

    logic              valid_q;
    logic [XLEN-1:0]   pc_q, imm_q, rs1_data_q, rs2_data_q;
    logic [4:0]        rd_addr_q, rs1_addr_q, rs2_addr_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic              reg_write_q, mem_read_q, mem_write_q, alu_src_imm_q;

    logic hazard;
    logic bubble;
    logic fwd1_ok, fwd2_ok;
    logic [XLEN-1:0] rs1_fwd, rs2_fwd;

    always_comb begin
        hazard = valid_q & mem_read_q & (rd_addr_q != 5'd0) & id_valid &
                 ((rd_addr_q == id_rs1_addr) | (rd_addr_q == id_rs2_addr));
        state_d     = StRun;
        stall_if_id = 1'b0;
        bubble      = 1'b0;
        unique case (state_q)
            StRun: begin
                if (flush) begin
                    bubble = 1'b1;
                end else if (hazard) begin
                    stall_if_id = 1'b1;
                    bubble      = 1'b1;
                    state_d     = StBubble;
                end
            end
            // Second pass of the held instruction; only a flush can kill it.
            StBubble: begin
                if (flush) bubble = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q       <= StRun;
            valid_q       <= 1'b0;
            pc_q          <= '0;
            imm_q         <= '0;
            rs1_data_q    <= '0;
            rs2_data_q    <= '0;
            rd_addr_q     <= '0;
            rs1_addr_q    <= '0;
            rs2_addr_q    <= '0;
            ctrl_q        <= '0;
            reg_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            alu_src_imm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (bubble) begin
                valid_q     <= 1'b0;
                reg_write_q <= 1'b0;
                mem_read_q  <= 1'b0;
                mem_write_q <= 1'b0;
            end else begin
                valid_q       <= id_valid;
                pc_q          <= id_pc;
                imm_q         <= id_imm;
                rs1_data_q    <= id_rs1_data;
                rs2_data_q    <= id_rs2_data;
                rd_addr_q     <= id_rd_addr;
                rs1_addr_q    <= id_rs1_addr;
                rs2_addr_q    <= id_rs2_addr;
                ctrl_q        <= id_ctrl;
                reg_write_q   <= id_reg_write;
                mem_read_q    <= id_mem_read;
                mem_write_q   <= id_mem_write;
                alu_src_imm_q <= id_alu_src_imm;
            end
        end
    end

    // x0 and empty slots never take a forwarded value.
    always_comb begin
        fwd1_ok = valid_q & (rs1_addr_q != 5'd0);
        fwd2_ok = valid_q & (rs2_addr_q != 5'd0);
        if (fwd1_ok & fwd_rs1_mem)     rs1_fwd = mem_result;
        else if (fwd1_ok & fwd_rs1_wb) rs1_fwd = wb_result;
        else                           rs1_fwd = rs1_data_q;
        if (fwd2_ok & fwd_rs2_mem)     rs2_fwd = mem_result;
        else if (fwd2_ok & fwd_rs2_wb) rs2_fwd = wb_result;
        else                           rs2_fwd = rs2_data_q;
    end

    assign ex_valid      = valid_q;
    assign ex_pc         = pc_q;
    assign ex_imm        = imm_q;
    assign ex_rd_addr    = rd_addr_q;
    assign ex_rs1_addr   = rs1_addr_q;
    assign ex_rs2_addr   = rs2_addr_q;
    assign ex_ctrl       = ctrl_q;
    assign ex_reg_write  = reg_write_q & valid_q;
    assign ex_mem_read   = mem_read_q & valid_q;
    assign ex_mem_write  = mem_write_q & valid_q;
    assign ex_operand_a  = rs1_fwd;
    assign ex_operand_b  = alu_src_imm_q ? imm_q : rs2_fwd;
    assign ex_store_data = rs2_fwd;

`ifdef PERF_COUNT_EN
    logic [31:0] bubble_count_q, flush_count_q;

    always_ff @(posedge clk) begin
        if (RESET) begin
            bubble_count_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (stall_if_id) bubble_count_q <= bubble_count_q + 32'd1;
            if (flush)       flush_count_q  <= flush_count_q + 32'd1;
        end
    end

    assign bubble_count = bubble_count_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them.
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        RESET;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [7:0]  id_ctrl;
    logic        id_reg_write, id_mem_read, id_mem_write, id_alu_src_imm;
    logic        flush;
    logic        fwd_rs1_mem, fwd_rs2_mem, fwd_rs1_wb, fwd_rs2_wb;
    logic [31:0] mem_result, wb_result;
    logic        stall_if_id, ex_valid;
    logic [31:0] ex_pc, ex_imm;
    logic [4:0]  ex_rd_addr, ex_rs1_addr, ex_rs2_addr;
    logic [7:0]  ex_ctrl;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;
    logic [31:0] ex_operand_a, ex_operand_b, ex_store_data;
`ifdef PERF_COUNT_EN
    logic [31:0] bubble_count, flush_count;
`endif

    always #5 clk = ~clk;

    id_ex_operand_stage #(.XLEN(32), .CTRL_W(8)) dut (
        .clk(clk), .RESET(RESET), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_ctrl(id_ctrl), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_alu_src_imm(id_alu_src_imm), .flush(flush),
        .fwd_rs1_mem(fwd_rs1_mem), .fwd_rs2_mem(fwd_rs2_mem), .fwd_rs1_wb(fwd_rs1_wb),
        .fwd_rs2_wb(fwd_rs2_wb), .mem_result(mem_result), .wb_result(wb_result),
        .stall_if_id(stall_if_id), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_rd_addr(ex_rd_addr), .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
        .ex_ctrl(ex_ctrl), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_operand_a(ex_operand_a),
        .ex_operand_b(ex_operand_b), .ex_store_data(ex_store_data)
`ifdef PERF_COUNT_EN
        , .bubble_count(bubble_count), .flush_count(flush_count)
`endif
    );

    typedef struct {
        logic        v, st, rw, mr, mw, chk;
        logic [31:0] pc, a, b, sd;
        logic [4:0]  rd;
        logic [31:0] bc, fc;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int unsigned exp_bub = 0;
    int unsigned exp_fl = 0;

    function automatic exp_t mk(input logic v, st, rw, mr, mw, chk, input logic [31:0] pc,
                                input logic [4:0] rd, input logic [31:0] a, b, sd);
        exp_t e;
        e.v = v; e.st = st; e.rw = rw; e.mr = mr; e.mw = mw; e.chk = chk;
        e.pc = pc; e.rd = rd; e.a = a; e.b = b; e.sd = sd;
        e.bc = 0; e.fc = 0; e.cyc = 0;
        return e;
    endfunction

    function automatic exp_t bub();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic exp_t zero_state();
        return mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    endfunction

    task automatic chk(input string name, input int c, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h, expected %h", name, c, act, req);
        end
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1, rs2, rd,
                          input logic [31:0] d1, d2, imm, input logic rw, mr, mw, src);
        id_valid = v; id_pc = pc; id_rs1_addr = rs1; id_rs2_addr = rs2; id_rd_addr = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_ctrl = pc[9:2];
        id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_alu_src_imm = src;
    endtask

    task automatic set_fwd(input logic r1m, r2m, r1w, r2w, input logic [31:0] m, w);
        fwd_rs1_mem = r1m; fwd_rs2_mem = r2m; fwd_rs1_wb = r1w; fwd_rs2_wb = r2w;
        mem_result = m; wb_result = w;
    endtask

    // Expectation covers the outputs seen during this cycle, before the next edge.
    task automatic step(input exp_t e_in);
        exp_t e;
        e = e_in;
        e.cyc = cyc; e.bc = exp_bub; e.fc = exp_fl;
        q.push_back(e);
        if (RESET) begin
            exp_bub = 0; exp_fl = 0;
        end else begin
            if (e.st) exp_bub++;
            if (flush) exp_fl++;
        end
        cyc++;
        @(posedge clk);
        #1;
        flush = 1'b0;
        set_fwd(0, 0, 0, 0, 32'h0, 32'h0);
    endtask

    initial begin : monitor
        exp_t e;
        logic [31:0] ctrl_req;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ex_valid", e.cyc, {31'd0, ex_valid}, {31'd0, e.v});
                chk("stall_if_id", e.cyc, {31'd0, stall_if_id}, {31'd0, e.st});
                chk("ex_reg_write", e.cyc, {31'd0, ex_reg_write}, {31'd0, e.rw});
                chk("ex_mem_read", e.cyc, {31'd0, ex_mem_read}, {31'd0, e.mr});
                chk("ex_mem_write", e.cyc, {31'd0, ex_mem_write}, {31'd0, e.mw});
                if (e.chk) begin
                    ctrl_req = {24'd0, e.pc[9:2]};
                    chk("ex_pc", e.cyc, ex_pc, e.pc);
                    chk("ex_rd_addr", e.cyc, {27'd0, ex_rd_addr}, {27'd0, e.rd});
                    chk("ex_ctrl", e.cyc, {24'd0, ex_ctrl}, ctrl_req);
                    chk("ex_operand_a", e.cyc, ex_operand_a, e.a);
                    chk("ex_operand_b", e.cyc, ex_operand_b, e.b);
                    chk("ex_store_data", e.cyc, ex_store_data, e.sd);
                end
`ifdef PERF_COUNT_EN
                chk("bubble_count", e.cyc, bubble_count, e.bc);
                chk("flush_count", e.cyc, flush_count, e.fc);
`endif
            end
        end
    end

    initial begin : stim
        RESET = 1'b1;
        flush = 1'b0;
        set_fwd(0, 0, 0, 0, 32'h0, 32'h0);
        set_id(1, 32'h100, 1, 2, 3, 32'h11, 32'h22, 32'h5, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        step(zero_state());
        // EX empty, so forwarding requests must not leak through
        set_fwd(1, 1, 1, 1, 32'hAA, 32'hBB);
        step(zero_state());
        RESET = 1'b0;
        step(zero_state());
        // lw x5 enters; add in EX takes MEM over WB
        set_id(1, 32'h104, 1, 0, 5, 32'h1000, 32'h0, 32'h8, 1, 1, 0, 1);
        set_fwd(1, 0, 1, 0, 32'hAA, 32'hBB);
        step(mk(1, 0, 1, 0, 0, 1, 32'h100, 3, 32'hAA, 32'h22, 32'h22));
        // add x6,x5,x1 vs lw x5: stall; WB-only rs1 forward; rs2=x0 guard
        set_id(1, 32'h108, 5, 1, 6, 32'h55, 32'h1000, 32'h0, 1, 0, 0, 0);
        set_fwd(0, 1, 1, 0, 32'hAA, 32'hBB);
        step(mk(1, 1, 1, 1, 0, 1, 32'h104, 5, 32'hBB, 32'h8, 32'h0));
        set_fwd(1, 1, 0, 0, 32'hAA, 32'h0);
        step(bub());
        set_id(1, 32'h10C, 2, 6, 0, 32'h2000, 32'h0, 32'h0, 0, 0, 1, 1);
        set_fwd(0, 0, 1, 0, 32'h0, 32'hCAFE);
        step(mk(1, 0, 1, 0, 0, 1, 32'h108, 6, 32'hCAFE, 32'h1000, 32'h1000));
        // store: operand_b is imm, store data forwarded from MEM
        set_id(1, 32'h110, 2, 0, 7, 32'h2000, 32'h0, 32'h4, 1, 1, 0, 1);
        set_fwd(0, 1, 0, 0, 32'h3333, 32'h0);
        step(mk(1, 0, 0, 0, 1, 1, 32'h10C, 0, 32'h2000, 32'h0, 32'h3333));
        // hazard and flush together: flush wins, no stall
        set_id(1, 32'h114, 7, 7, 8, 32'h0, 32'h0, 32'h0, 1, 0, 0, 0);
        flush = 1'b1;
        step(mk(1, 0, 1, 1, 0, 1, 32'h110, 7, 32'h2000, 32'h4, 32'h0));
        set_id(1, 32'h200, 1, 2, 9, 32'h10, 32'h20, 32'h0, 1, 0, 0, 0);
        step(bub());
        set_id(1, 32'h204, 1, 0, 0, 32'h10, 32'h0, 32'h0, 1, 1, 0, 1);
        step(mk(1, 0, 1, 0, 0, 1, 32'h200, 9, 32'h10, 32'h20, 32'h20));
        // load to x0 never stalls
        set_id(1, 32'h208, 0, 0, 11, 32'h0, 32'h0, 32'h0, 1, 0, 0, 0);
        step(mk(1, 0, 1, 1, 0, 1, 32'h204, 0, 32'h10, 32'h0, 32'h0));
        set_id(1, 32'h300, 1, 0, 10, 32'h40, 32'h0, 32'h0, 1, 1, 0, 1);
        set_fwd(1, 0, 0, 1, 32'hAA, 32'hBB);
        step(mk(1, 0, 1, 0, 0, 1, 32'h208, 11, 32'h0, 32'h0, 32'h0));
        // rs2 match stalls
        set_id(1, 32'h304, 3, 10, 0, 32'h30, 32'h0, 32'h0, 0, 0, 1, 1);
        step(mk(1, 1, 1, 1, 0, 1, 32'h300, 10, 32'h40, 32'h0, 32'h0));
        // flush in the bubble cycle kills the held instruction
        flush = 1'b1;
        step(bub());
        set_id(1, 32'h400, 1, 0, 12, 32'h50, 32'h0, 32'h0, 1, 1, 0, 1);
        step(bub());
        set_id(0, 32'h404, 12, 0, 13, 32'h0, 32'h0, 32'h0, 1, 0, 0, 0);
        step(mk(1, 0, 1, 1, 0, 1, 32'h400, 12, 32'h50, 32'h0, 32'h0));
        set_id(1, 32'h404, 12, 0, 13, 32'h0, 32'h0, 32'h0, 1, 0, 0, 0);
        step(bub());
        set_id(1, 32'h408, 1, 0, 14, 32'h60, 32'h0, 32'h0, 1, 1, 0, 1);
        set_fwd(1, 0, 0, 0, 32'h1234, 32'h0);
        step(mk(1, 0, 1, 0, 0, 1, 32'h404, 13, 32'h1234, 32'h0, 32'h0));
        set_id(1, 32'h40C, 14, 14, 15, 32'h70, 32'h70, 32'h0, 1, 0, 0, 0);
        step(mk(1, 1, 1, 1, 0, 1, 32'h408, 14, 32'h60, 32'h0, 32'h0));
        step(bub());
        set_id(0, 32'h500, 1, 2, 3, 32'h0, 32'h0, 32'h0, 1, 1, 1, 0);
        step(mk(1, 0, 1, 0, 0, 1, 32'h40C, 15, 32'h70, 32'h70, 32'h70));
        RESET = 1'b1;
        set_id(1, 32'h600, 1, 2, 3, 32'h9, 32'h9, 32'h9, 1, 1, 1, 1);
        step(bub());
        step(zero_state());
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        checks++;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
